// File: rtl/conv_result_drain_if.sv
// Result-drain bus: per-channel result-RAM write port plus the drained pixel stream.
// slave  = the drain block (accepts writes, sources the stream)
// master = the conv engine / downstream side (drives writes, sinks the stream)
interface conv_result_drain_if #(
  parameter int DATA_WIDTH            = 8,
  parameter int RESULT_D              = 8,
  parameter int RESULT_RAM_ADDR_WIDTH = 6
);
  logic [RESULT_RAM_ADDR_WIDTH*RESULT_D-1:0] result_wraddress;
  logic [DATA_WIDTH*RESULT_D-1:0]            result_data_out;
  logic [RESULT_D-1:0]                       result_wren;
  logic                                      fill_rdy;
  logic [DATA_WIDTH*RESULT_D-1:0]            out_data;
  logic                                      out_val;
  logic                                      out_rdy;
  logic                                      out_last;
  logic                                      overflow;

  modport slave (
    input  result_wraddress, result_data_out, result_wren, out_rdy,
    output fill_rdy, out_data, out_val, out_last, overflow
  );

  modport master (
    output result_wraddress, result_data_out, result_wren, out_rdy,
    input  fill_rdy, out_data, out_val, out_last, overflow
  );
endinterface

// File: rtl/conv_result_drain.sv
// conv_result_drain: collects one result frame through per-channel RAM write ports,
// then drains it in raster order as a valid/ready stream, one pixel (all channels) per beat.
// Optional feature: define CONV_DRAIN_RELU_EN to clamp negative (MSB set) output elements
// to zero in the output register.
module conv_result_drain #(
  parameter int DATA_WIDTH            = 8,
  parameter int RESULT_W              = 6,
  parameter int RESULT_H              = 6,
  parameter int RESULT_D              = 8,
  parameter int RESULT_N              = RESULT_W * RESULT_H,
  parameter int RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_N)
) (
  input logic                 clk,
  input logic                 reset,
  conv_result_drain_if.slave  bus
);

  localparam int DW    = DATA_WIDTH;
  localparam int AW    = RESULT_RAM_ADDR_WIDTH;
  localparam int CNT_W = $clog2(RESULT_N + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RESULT_N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESULT_N - 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_PRIME,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0]    mem_q [RESULT_D][RESULT_N];
  logic [CNT_W-1:0] wr_cnt_q [RESULT_D];
  logic [CNT_W-1:0] wr_cnt_d [RESULT_D];
  logic [AW-1:0]    wr_addr [RESULT_D];
  logic [DW-1:0]    wr_data [RESULT_D];
  logic [RESULT_D-1:0] wr_ok;
  logic             all_full;

  // Read pipeline: RAM read register followed by the output register.
  logic [CNT_W-1:0] rd_addr_q;
  logic [DW-1:0]    rd_data_q [RESULT_D];
  logic             rd_vld_q;
  logic             rd_last_q;

  logic [DW*RESULT_D-1:0] out_data_q;
  logic                   out_val_q;
  logic                   out_last_q;
  logic                   overflow_q;

  logic adv;
  logic rd_issue;
  logic fin;

  function automatic logic [DW-1:0] out_xform(input logic [DW-1:0] v);
`ifdef CONV_DRAIN_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Unpack per-channel write slices and qualify writes (only in FILL, only in range)
  always_comb begin
    wr_ok = '0;
    for (int unsigned k = 0; k < RESULT_D; k++) begin
      wr_addr[k] = bus.result_wraddress[k*AW +: AW];
      wr_data[k] = bus.result_data_out[k*DW +: DW];
      wr_ok[k]   = (state_q == S_FILL) && bus.result_wren[k] &&
                   (CNT_W'(wr_addr[k]) < CNT_FULL);
    end
  end

  // Handshake qualifiers shared by the FSM and the read pipeline.
  // The whole pipeline advances only when the output register is empty or being taken,
  // so a stall freezes the RAM read register too and no beat is lost or repeated.
  always_comb begin
    adv      = !out_val_q || bus.out_rdy;
    fin      = (state_q == S_DRAIN) && out_val_q && bus.out_rdy && out_last_q;
    rd_issue = ((state_q == S_PRIME) || (state_q == S_DRAIN)) && adv &&
               (rd_addr_q < CNT_FULL);
  end

  // Per-channel write counters (saturating) and the frame-complete detect
  always_comb begin
    all_full = 1'b1;
    for (int unsigned k = 0; k < RESULT_D; k++) begin
      wr_cnt_d[k] = wr_cnt_q[k];
      if ((state_q == S_FILL) && bus.result_wren[k] && (wr_cnt_q[k] < CNT_FULL)) begin
        wr_cnt_d[k] = wr_cnt_q[k] + 1'b1;
      end
      if (wr_cnt_d[k] != CNT_FULL) begin
        all_full = 1'b0;
      end
      if (fin) begin
        wr_cnt_d[k] = '0;
      end
    end
  end

  // Next-state logic for FILL -> PRIME -> DRAIN -> FILL
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FILL:  if (all_full) state_d = S_PRIME;
      S_PRIME: state_d = S_DRAIN;
      S_DRAIN: if (fin) state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  // State register and write counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FILL;
      for (int unsigned k = 0; k < RESULT_D; k++) begin
        wr_cnt_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      for (int unsigned k = 0; k < RESULT_D; k++) begin
        wr_cnt_q[k] <= wr_cnt_d[k];
      end
    end
  end

  // Result RAMs: synchronous write, registered read gated by pipeline advance
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < RESULT_D; k++) begin
      if (wr_ok[k]) begin
        mem_q[k][wr_addr[k]] <= wr_data[k];
      end
      if (rd_issue) begin
        rd_data_q[k] <= mem_q[k][rd_addr_q];
      end
    end
  end

  // Read address, read-stage valid/last and output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr_q  <= '0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      out_data_q <= '0;
      out_val_q  <= 1'b0;
      out_last_q <= 1'b0;
    end else if (fin) begin
      rd_addr_q  <= '0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      out_val_q  <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      if (state_q == S_FILL) begin
        rd_addr_q <= '0;
      end
      if (adv) begin
        out_val_q  <= rd_vld_q;
        out_last_q <= rd_vld_q && rd_last_q;
        if (rd_vld_q) begin
          for (int unsigned k = 0; k < RESULT_D; k++) begin
            out_data_q[k*DW +: DW] <= out_xform(rd_data_q[k]);
          end
        end
        if (rd_issue) begin
          rd_vld_q  <= 1'b1;
          rd_last_q <= (rd_addr_q == CNT_LAST);
          rd_addr_q <= rd_addr_q + 1'b1;
        end else begin
          rd_vld_q  <= 1'b0;
          rd_last_q <= 1'b0;
        end
      end
    end
  end

  // Sticky flag for writes arriving while the frame is not being filled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if ((state_q != S_FILL) && (|bus.result_wren)) begin
      overflow_q <= 1'b1;
    end
  end

  assign bus.fill_rdy = (state_q == S_FILL);
  assign bus.out_data = out_data_q;
  assign bus.out_val  = out_val_q;
  assign bus.out_last = out_last_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_conv_result_drain.sv
// Directed bench for conv_result_drain: fill/drain, back-pressure, staggered fills,
// overflow, mid-drain reset and the optional ReLU output clamp.
module tb_conv_result_drain;

  localparam int DW = 8;
  localparam int D  = 8;
  localparam int N  = 36;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  conv_result_drain_if #(
    .DATA_WIDTH(DW),
    .RESULT_D(D),
    .RESULT_RAM_ADDR_WIDTH(AW)
  ) bus ();

  conv_result_drain #(
    .DATA_WIDTH(DW),
    .RESULT_W(6),
    .RESULT_H(6),
    .RESULT_D(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stored value for channel k, address a. base<0 selects the sign-test frame.
  function automatic logic [7:0] gen(input int k, input int a, input int base);
    int v;
    if (base < 0) begin
      case (a)
        0:       v = 8'h80;
        1:       v = 8'hFF;
        2:       v = 8'h7F;
        3:       v = 8'h00;
        default: v = k * 16 + a;
      endcase
    end else begin
      v = k * 16 + a + base;
    end
    return v[7:0];
  endfunction

  function automatic logic [7:0] expv(input int k, input int a, input int base);
    logic [7:0] v;
    v = gen(k, a, base);
`ifdef CONV_DRAIN_RELU_EN
    if (v[7]) v = 8'h00;
`endif
    return v;
  endfunction

  function automatic logic [63:0] exp_beat(input int a, input int base);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < D; k++) r[k*8 +: 8] = expv(k, a, base);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic en, input int a, input int base);
    bus.result_wren[k]               = en;
    bus.result_wraddress[k*AW +: AW] = a[AW-1:0];
    bus.result_data_out[k*DW +: DW]  = gen(k, a, base);
  endtask

  // After the cycle holding the last fill write: PRIME, then two more cycles to out_val
  task automatic check_latency(input string tag);
    chk({tag, "_fill_rdy_t1"}, bus.fill_rdy, 1'b0);
    chk({tag, "_val_t1"}, bus.out_val, 1'b0);
    tick();
    chk({tag, "_val_t2"}, bus.out_val, 1'b0);
    tick();
    chk({tag, "_val_t3"}, bus.out_val, 1'b1);
  endtask

  task automatic fill_all(input int base);
    for (int a = 0; a < N; a++) begin
      for (int k = 0; k < D; k++) set_ch(k, 1'b1, a, base);
      tick();
    end
    bus.result_wren = '0;
  endtask

  // stall: out_rdy follows 1,0,0,1; stop_at<N leaves the frame mid-drain
  task automatic drain(input string tag, input int base, input bit stall,
                       input int stop_at, input bit inject);
    int b;
    int c;
    b = 0;
    c = 0;
    while (b < stop_at && c < 400) begin
      bus.out_rdy = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      if (inject) begin
        bus.result_wren                  = (c == 0) ? 8'h04 : 8'h00;
        bus.result_wraddress[2*AW +: AW] = 6'd5;
        bus.result_data_out[2*DW +: DW]  = 8'hEE;
      end
      chk({tag, "_val"}, bus.out_val, 1'b1);
      chk({tag, "_data"}, bus.out_data, exp_beat(b, base));
      chk({tag, "_last"}, bus.out_last, (b == N - 1));
      if (bus.out_rdy) b++;
      tick();
      c++;
    end
    bus.out_rdy = 1'b1;
    chk({tag, "_beats"}, b, stop_at);
    if (stop_at == N) begin
      chk({tag, "_end_val"}, bus.out_val, 1'b0);
      chk({tag, "_end_last"}, bus.out_last, 1'b0);
      chk({tag, "_end_fill_rdy"}, bus.fill_rdy, 1'b1);
    end
  endtask

  initial begin
    int off [D];
    int a;
    logic en;

    reset                = 1'b0;
    bus.result_wren      = '0;
    bus.result_wraddress = '0;
    bus.result_data_out  = '0;
    bus.out_rdy          = 1'b1;
    tick();
    tick();
    chk("rst_fill_rdy", bus.fill_rdy, 1'b1);
    chk("rst_val", bus.out_val, 1'b0);
    chk("rst_last", bus.out_last, 1'b0);
    chk("rst_data", bus.out_data, 64'h0);
    chk("rst_ovf", bus.overflow, 1'b0);
    reset = 1'b1;
    tick();

    // Basic frame, sink always ready
    fill_all(0);
    check_latency("t1");
    drain("t1", 0, 1'b0, N, 1'b0);

    // Same frame with back-pressure
    fill_all(0);
    check_latency("t2");
    drain("t2", 0, 1'b1, N, 1'b0);
    chk("t2_ovf", bus.overflow, 1'b0);

    // Staggered channels: ch k starts at cycle k, ch 7 at cycle 10
    for (int k = 0; k < D; k++) off[k] = (k == 7) ? 10 : k;
    for (int c = 0; c < 46; c++) begin
      for (int k = 0; k < D; k++) begin
        a  = c - off[k];
        en = (a >= 0) && (a < N);
        set_ch(k, en, en ? a : 0, 8'h30);
      end
      if (c == 45) begin
        chk("t3_fill_rdy_before", bus.fill_rdy, 1'b1);
        chk("t3_val_before", bus.out_val, 1'b0);
      end
      tick();
    end
    bus.result_wren = '0;
    check_latency("t3");
    drain("t3", 8'h30, 1'b0, N, 1'b0);

    // Write during DRAIN is dropped and flagged
    fill_all(0);
    check_latency("t4");
    drain("t4", 0, 1'b0, N, 1'b1);
    chk("t4_ovf", bus.overflow, 1'b1);

    // Reset in the middle of a drain, then a fresh frame
    fill_all(8'h11);
    check_latency("t5a");
    drain("t5a", 8'h11, 1'b0, 10, 1'b0);
    reset = 1'b0;
    #1;
    chk("t5_rst_val", bus.out_val, 1'b0);
    chk("t5_rst_last", bus.out_last, 1'b0);
    chk("t5_rst_fill_rdy", bus.fill_rdy, 1'b1);
    chk("t5_rst_ovf", bus.overflow, 1'b0);
    #2;
    reset = 1'b1;
    tick();
    fill_all(8'h22);
    check_latency("t5b");
    drain("t5b", 8'h22, 1'b0, N, 1'b0);
    chk("t5_ovf_after", bus.overflow, 1'b0);

    // Sign-boundary values 0x80, 0xFF, 0x7F, 0x00 at addresses 0..3
    fill_all(-1);
    check_latency("t6");
    drain("t6", -1, 1'b0, N, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
